sdm_tx: RTL and testbench
=========================

# sdm_tx

Six-channel first-order digital sigma-delta modulator that regenerates the 1-bit current/voltage bitstreams (i1, u1, i2, u2, i3, u3) normally produced by the external ADC modulators. It accepts parallel signed sample sets over a valid/ready handshake and emits one bitstream per channel, driving the ADC data-capture inputs in loopback self-test and in bench stimulus for the metering chain.

## Interface
- DW, 16: signed sample width; full scale FS = 2^(DW-1).
- OSR, 64: modulator ticks per sample frame (≥2).
- CLK_DIV, 4: mclkin cycles per modulator tick (≥1; 1 = tick every cycle).
- mclkin  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  modulator run enable.
- s_valid  in  1  sample set valid.
- s_ready  out  1  sample set accepted this cycle when high with s_valid.
- s_i1, s_u1, s_i2, s_u2, s_i3, s_u3  in  DW each  signed two's-complement samples.
- sd_i1, sd_u1, sd_i2, sd_u2, sd_i3, sd_u3  out  1 each  modulator bitstreams (registered).
- bit_stb  out  1  one-cycle pulse, high on every tick cycle (the cycle in which sd_* update).
- frame_stb  out  1  one-cycle pulse on the last tick of each frame.
- underrun  out  1  sticky: a frame ended with no new sample available.
- clr_underrun  in  1  synchronous clear of underrun.

## Operation
- Divider: counter 0..CLK_DIV-1; tick when counter == CLK_DIV-1 and en=1.
- Frame counter 0..OSR-1, advances on tick; frame boundary = tick with counter == OSR-1 (frame_stb=1).
- Buffering: active set (6×DW, drives modulators) and next set (6×DW) with flag next_full.
- s_ready = !next_full. Accept (s_valid & s_ready) writes next, sets next_full.
- At frame boundary: next_full=1 → active <= next, next_full <= 0. next_full=0 and s_valid=1 → sample loads directly into active, next_full stays 0, no underrun. next_full=0 and s_valid=0 → active held, underrun <= 1.
- Non-boundary accept never touches active.
- clr_underrun clears underrun; simultaneous new underrun event wins (underrun=1).
- Modulator per channel, accumulator a signed DW+2 bits, output bit b. On each tick: f = b ? +FS : -FS; a <= a + x - f; b <= (a + x - f) >= 0, where x = channel's active sample sign-extended. |a| ≤ 2·FS for all inputs; no saturation needed.
- en=0: divider, frame counter, all a, b cleared to 0 synchronously and held; bit_stb, frame_stb low; handshake, buffers and underrun unaffected. First tick after en rises begins frame bit 0.

## Timing
- Reset values: sd_*=0, bit_stb=0, frame_stb=0, underrun=0, s_ready=1 (next_full=0), all accumulators 0, active set 0, counters 0.
- sd_* change only on the mclkin edge ending a tick cycle; stable for CLK_DIV cycles.
- Sample accepted during frame N is used from the first tick of frame N+1 (boundary load is on the frame_stb edge).
- s_ready falls the cycle after an accept; rises the cycle after the boundary that consumes next.
- Reset mid-frame: immediate return to reset values; in-flight next set discarded.

## Test plan
- DW=16, x=0 on all channels, en=1: after reset, bits from tick 1 are 1,1,0,1,0,1,0…; ones over 64 ticks = 32±1.
- x=+16384 on sd_i1, x=-16384 on sd_u1: ones in 64-tick frame = 48±1 and 16±1 respectively; other channels at 0 give 32±1.
- x=-32768 constant: bits 1,0,0,0… (a settles at -65536, never overflows); x=+32767: ones over 64 ticks ≥ 63.
- Handshake: s_valid held high with new values each accept: exactly one accept per frame after the first fill, s_ready low between, values appear in sd_* density one frame after accept; underrun stays 0.
- Starve: no s_valid for two frames -> underrun=1 at first boundary, bitstreams continue from held sample; clr_underrun pulse -> 0; s_valid exactly on boundary with next empty -> direct load, underrun unchanged.
- CLK_DIV=4: bit_stb every 4th cycle, frame_stb every 256 cycles; en dropped mid-frame -> sd_*=0 next cycle, restart at frame bit 0; rst asserted mid-frame -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/sdm_tx.sv
// Six-channel first-order sigma-delta modulator with a double-buffered sample set.
// Bitstreams regenerate the ADC modulator outputs for loopback and bench stimulus.
module sdm_tx #(
    parameter int DW      = 16,
    parameter int OSR     = 64,
    parameter int CLK_DIV = 4
) (
    input  logic                 mclkin,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_i1,
    input  logic signed [DW-1:0] s_u1,
    input  logic signed [DW-1:0] s_i2,
    input  logic signed [DW-1:0] s_u2,
    input  logic signed [DW-1:0] s_i3,
    input  logic signed [DW-1:0] s_u3,
    output logic                 sd_i1,
    output logic                 sd_u1,
    output logic                 sd_i2,
    output logic                 sd_u2,
    output logic                 sd_i3,
    output logic                 sd_u3,
    output logic                 bit_stb,
    output logic                 frame_stb,
    output logic                 underrun,
    input  logic                 clr_underrun
);

    localparam int AW   = DW + 2;
    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FRW  = $clog2(OSR);
    localparam logic signed [AW-1:0] FS = {3'b001, {(DW-1){1'b0}}};

    logic [DIVW-1:0]        r_div;
    logic [FRW-1:0]         r_frm;
    logic                   r_next_full;
    logic                   r_underrun;
    logic signed [DW-1:0]   r_act [6];
    logic signed [DW-1:0]   r_nxt [6];
    logic signed [AW-1:0]   r_acc [6];
    logic [5:0]             r_bit;

    logic signed [DW-1:0]   w_smp [6];
    logic signed [AW-1:0]   w_sum [6];
    logic                   w_div_end;
    logic                   w_tick;
    logic                   w_boundary;
    logic                   w_accept;
    logic                   w_under_evt;

    assign w_smp[0] = s_i1;
    assign w_smp[1] = s_u1;
    assign w_smp[2] = s_i2;
    assign w_smp[3] = s_u2;
    assign w_smp[4] = s_i3;
    assign w_smp[5] = s_u3;

    assign w_div_end   = (r_div == DIVW'(CLK_DIV - 1));
    assign w_tick      = en & w_div_end;
    assign w_boundary  = w_tick & (r_frm == FRW'(OSR - 1));
    assign w_accept    = s_valid & ~r_next_full;
    assign w_under_evt = w_boundary & ~r_next_full & ~s_valid;

    // Next accumulator value per channel: a + x - (b ? +FS : -FS)
    always_comb begin
        for (int c = 0; c < 6; c++) begin
            w_sum[c] = r_acc[c] + {{2{r_act[c][DW-1]}}, r_act[c]} - (r_bit[c] ? FS : -FS);
        end
    end

    // Tick divider, frame position and the six modulators; all parked at zero while disabled
    always_ff @(posedge mclkin or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_frm <= '0;
            r_bit <= 6'b000000;
            for (int c = 0; c < 6; c++) r_acc[c] <= '0;
        end else if (!en) begin
            r_div <= '0;
            r_frm <= '0;
            r_bit <= 6'b000000;
            for (int c = 0; c < 6; c++) r_acc[c] <= '0;
        end else begin
            r_div <= w_div_end ? DIVW'(0) : r_div + DIVW'(1);
            if (w_tick) begin
                r_frm <= (r_frm == FRW'(OSR - 1)) ? FRW'(0) : r_frm + FRW'(1);
                for (int c = 0; c < 6; c++) begin
                    r_acc[c] <= w_sum[c];
                    r_bit[c] <= ~w_sum[c][AW-1];
                end
            end
        end
    end

    // Sample buffering: a sample offered on an empty-buffer boundary bypasses straight to active
    always_ff @(posedge mclkin or posedge rst) begin
        if (rst) begin
            r_next_full <= 1'b0;
            r_underrun  <= 1'b0;
            for (int c = 0; c < 6; c++) begin
                r_act[c] <= '0;
                r_nxt[c] <= '0;
            end
        end else begin
            if (w_boundary) begin
                if (r_next_full) begin
                    r_next_full <= 1'b0;
                    for (int c = 0; c < 6; c++) r_act[c] <= r_nxt[c];
                end else if (s_valid) begin
                    for (int c = 0; c < 6; c++) r_act[c] <= w_smp[c];
                end
            end else if (w_accept) begin
                r_next_full <= 1'b1;
                for (int c = 0; c < 6; c++) r_nxt[c] <= w_smp[c];
            end
            if (w_under_evt) begin
                r_underrun <= 1'b1;
            end else if (clr_underrun) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign s_ready   = ~r_next_full;
    assign underrun  = r_underrun;
    assign bit_stb   = w_tick;
    assign frame_stb = w_boundary;
    assign sd_i1     = r_bit[0];
    assign sd_u1     = r_bit[1];
    assign sd_i2     = r_bit[2];
    assign sd_u2     = r_bit[3];
    assign sd_i3     = r_bit[4];
    assign sd_u3     = r_bit[5];

endmodule

// File: tb/tb_sdm_tx.sv
// Randomised scoreboard bench for sdm_tx: a tick-count reference model predicts every
// bitstream tick, strobe, handshake and underrun state, and a negedge monitor compares.
module tb_sdm_tx;

    localparam int DW      = 16;
    localparam int OSR     = 64;
    localparam int CLK_DIV = 4;
    localparam int FS      = 32768;

    logic mclkin, rst, en, s_valid, clr_underrun;
    logic signed [15:0] s_in [6];
    logic s_ready, bit_stb, frame_stb, underrun;
    logic sd_i1, sd_u1, sd_i2, sd_u2, sd_i3, sd_u3;
    logic [5:0] sd_v;

    assign sd_v = {sd_u3, sd_i3, sd_u2, sd_i2, sd_u1, sd_i1};

    sdm_tx #(.DW(DW), .OSR(OSR), .CLK_DIV(CLK_DIV)) dut (
        .mclkin(mclkin), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
        .s_i1(s_in[0]), .s_u1(s_in[1]), .s_i2(s_in[2]), .s_u2(s_in[3]),
        .s_i3(s_in[4]), .s_u3(s_in[5]),
        .sd_i1(sd_i1), .sd_u1(sd_u1), .sd_i2(sd_i2), .sd_u2(sd_u2),
        .sd_i3(sd_i3), .sd_u3(sd_u3),
        .bit_stb(bit_stb), .frame_stb(frame_stb), .underrun(underrun),
        .clr_underrun(clr_underrun)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: counts of enabled cycles and ticks since enable rose
    int   m_ecnt = 0;
    int   m_tcnt = 0;
    int   m_act [6] = '{0, 0, 0, 0, 0, 0};
    int   m_nxt [6] = '{0, 0, 0, 0, 0, 0};
    int   m_acc [6] = '{0, 0, 0, 0, 0, 0};
    logic [5:0] m_b = 6'b000000;
    logic m_nf  = 1'b0;
    logic m_und = 1'b0;
    logic [5:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic signed [15:0] rnd_sample();
        int r;
        r = $urandom % 8;
        case (r)
            0:       return 16'sh8000;
            1:       return 16'sh7fff;
            2:       return 16'sh0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        mclkin = 1'b0;
        forever #5 mclkin = ~mclkin;
    end

    // Behavioural model, advanced on each clock edge (or immediately on reset)
    initial begin
        logic tick, bnd, acc_ok, evt;
        forever begin
            @(posedge mclkin or posedge rst);
            if (rst) begin
                m_ecnt = 0; m_tcnt = 0; m_nf = 1'b0; m_und = 1'b0; m_b = 6'b000000;
                for (int c = 0; c < 6; c++) begin
                    m_act[c] = 0; m_nxt[c] = 0; m_acc[c] = 0;
                end
                exp_q.delete();
            end else begin
                tick   = en && (m_ecnt % CLK_DIV == CLK_DIV - 1);
                bnd    = tick && (m_tcnt % OSR == OSR - 1);
                acc_ok = s_valid && !m_nf;
                evt    = bnd && !m_nf && !s_valid;
                if (!en) begin
                    m_ecnt = 0; m_tcnt = 0; m_b = 6'b000000;
                    for (int c = 0; c < 6; c++) m_acc[c] = 0;
                end else begin
                    m_ecnt++;
                    if (tick) begin
                        m_tcnt++;
                        for (int c = 0; c < 6; c++) begin
                            m_acc[c] = m_acc[c] + m_act[c] - (m_b[c] ? FS : -FS);
                            m_b[c]   = (m_acc[c] >= 0);
                        end
                        exp_q.push_back(m_b);
                    end
                end
                if (bnd) begin
                    if (m_nf) begin
                        for (int c = 0; c < 6; c++) m_act[c] = m_nxt[c];
                        m_nf = 1'b0;
                    end else if (s_valid) begin
                        for (int c = 0; c < 6; c++) m_act[c] = int'(s_in[c]);
                    end
                end else if (acc_ok) begin
                    for (int c = 0; c < 6; c++) m_nxt[c] = int'(s_in[c]);
                    m_nf = 1'b1;
                end
                if (evt) m_und = 1'b1;
                else if (clr_underrun) m_und = 1'b0;
            end
        end
    end

    // Monitor: per-cycle state checks, plus scoreboard pop after each DUT tick
    initial begin
        logic pending, exp_tick, exp_bnd;
        logic [5:0] exp_bits;
        pending = 1'b0;
        forever begin
            @(negedge mclkin);
            exp_tick = !rst && en && (m_ecnt % CLK_DIV == CLK_DIV - 1);
            exp_bnd  = exp_tick && (m_tcnt % OSR == OSR - 1);
            chk("bit_stb", 32'(bit_stb), 32'(exp_tick));
            chk("frame_stb", 32'(frame_stb), 32'(exp_bnd));
            chk("s_ready", 32'(s_ready), 32'(!m_nf));
            chk("underrun", 32'(underrun), 32'(m_und));
            chk("sd_state", 32'(sd_v), 32'(m_b));
            if (pending && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("sd_tick_queue_empty", 32'(1), 32'(0));
                end else begin
                    exp_bits = exp_q.pop_front();
                    chk("sd_tick", 32'(sd_v), 32'(exp_bits));
                end
            end
            pending = bit_stb && !rst;
        end
    end

    int vprob;
    int clr_prob;
    int en_prob;

    // One stimulus cycle: hold offered data until accepted, otherwise re-roll
    task automatic step();
        logic rdy;
        @(negedge mclkin);
        rdy = s_ready;
        @(posedge mclkin);
        #2;
        clr_underrun = (($urandom % 100) < clr_prob);
        if (en_prob > 0 && ($urandom % 1000) < en_prob) en = ~en;
        else if (!en && ($urandom % 4) == 0) en = 1'b1;
        if (!(s_valid && !rdy)) begin
            s_valid = (($urandom % 100) < vprob);
            for (int c = 0; c < 6; c++) s_in[c] = rnd_sample();
        end
    endtask

    initial begin
        logic found;
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; clr_underrun = 1'b0;
        vprob = 0; clr_prob = 0; en_prob = 0;
        for (int c = 0; c < 6; c++) s_in[c] = 16'sh0000;
        repeat (3) @(posedge mclkin);
        #2;
        chk("reset_s_ready", 32'(s_ready), 32'(1));
        chk("reset_sd", 32'(sd_v), 32'(0));
        rst = 1'b0;
        en  = 1'b1;

        // Zero input first, then continuous supply: one accept per frame
        repeat (OSR * CLK_DIV) step();
        vprob = 100;
        repeat (4 * OSR * CLK_DIV) step();

        // Starve for three frames, then clear underrun
        vprob = 0;
        repeat (3 * OSR * CLK_DIV) step();
        @(posedge mclkin); #2;
        clr_underrun = 1'b1;
        @(posedge mclkin); #2;
        clr_underrun = 1'b0;

        // Offer a sample exactly on a boundary with next empty
        found = 1'b0;
        for (int i = 0; i < 2 * OSR * CLK_DIV && !found; i++) begin
            @(posedge mclkin); #2;
            if (en && (m_ecnt % CLK_DIV == CLK_DIV - 1) && (m_tcnt % OSR == OSR - 1) && !m_nf) begin
                found = 1'b1;
                s_valid = 1'b1;
                for (int c = 0; c < 6; c++) s_in[c] = rnd_sample();
            end
        end
        chk("boundary_found", 32'(found), 32'(1));
        @(posedge mclkin); #2;
        s_valid = 1'b0;
        repeat (OSR * CLK_DIV) step();

        // Random traffic with underrun clears and enable drops
        vprob = 3; clr_prob = 2; en_prob = 2;
        repeat (8 * OSR * CLK_DIV) step();

        // Asynchronous reset mid-frame
        en_prob = 0; en = 1'b1; vprob = 100;
        repeat (100) step();
        @(posedge mclkin); #3;
        rst = 1'b1;
        #1;
        chk("async_rst_sd", 32'(sd_v), 32'(0));
        chk("async_rst_s_ready", 32'(s_ready), 32'(1));
        chk("async_rst_underrun", 32'(underrun), 32'(0));
        chk("async_rst_bit_stb", 32'(bit_stb), 32'(0));
        chk("async_rst_frame_stb", 32'(frame_stb), 32'(0));
        repeat (2) @(posedge mclkin);
        #2;
        rst = 1'b0;
        vprob = 40;
        repeat (2 * OSR * CLK_DIV) step();

        repeat (2) @(posedge mclkin);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
